video_timing_gen: RTL

//  Raster timing source at the head of the nn_rgb pixel pipeline.

---
 rtl/video_timing_pkg.sv | 35 +++
 rtl/video_timing_if.sv | 34 +++
 rtl/vtg_axis_counter.sv | 28 ++
 rtl/video_timing_gen.sv | 117 +++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: types and helpers shared by the video timing generator.
//   timing_t     : one axis of raster timing (active, front porch, sync, back porch)
//   total()      : full period of an axis
//   sync_start() : first position of the sync pulse on an axis
//   BAR_RGB      : colour-bar table, index 0 = leftmost bar (white)
package video_timing_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } timing_t;

  function automatic int total(timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  function automatic int sync_start(timing_t t);
    return t.active + t.fp;
  endfunction

  // Packed so that BAR_RGB[i] selects bar i; the last element listed is index 0.
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000,  // 7 black
    24'h0000FF,  // 6 blue
    24'hFF0000,  // 5 red
    24'hFF00FF,  // 4 magenta
    24'h00FF00,  // 3 green
    24'h00FFFF,  // 2 cyan
    24'hFFFF00,  // 1 yellow
    24'hFFFFFF   // 0 white
  };

endpackage

// File: rtl/video_timing_if.sv
// video_timing_if: raster output bundle of the video timing generator.
//   master : driven by the generator (vs/hs/de, x/y, sof/eol, frame_cnt)
//   slave  : consumed by the sync delay stage and pixel fetch logic
// Optional macro VTG_TPG_EN adds rgb_out (24-bit colour-bar pattern).
interface video_timing_if #(
  parameter int XW = 11,
  parameter int YW = 10
);
  logic          vs_out;
  logic          hs_out;
  logic          de_out;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic          sof_out;
  logic          eol_out;
  logic [15:0]   frame_cnt;
`ifdef VTG_TPG_EN
  logic [23:0]   rgb_out;
`endif

  modport master (
    output vs_out, hs_out, de_out, x_out, y_out, sof_out, eol_out, frame_cnt
`ifdef VTG_TPG_EN
    , rgb_out
`endif
  );

  modport slave (
    input vs_out, hs_out, de_out, x_out, y_out, sof_out, eol_out, frame_cnt
`ifdef VTG_TPG_EN
    , rgb_out
`endif
  );
endinterface

// File: rtl/vtg_axis_counter.sv
// vtg_axis_counter: wrap-around position counter for one raster axis.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   en         : advance by one this cycle
//   max        : last position before wrapping back to 0
//   count      : current position
//   carry      : high in the enabled cycle where count wraps
module vtg_axis_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] max,
  output logic [W-1:0] count,
  output logic         carry
);

  assign carry = en && (count == max);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= carry ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing source for the nn_rgb pixel pipeline.
//   clk   : single rising-edge clock
//   reset : synchronous, active-high; wins over en
//   en    : pixel enable, 0 freezes all state (sof/eol forced low)
//   vid   : video_timing_if master (vs/hs/de, x/y, sof/eol, frame_cnt)
// Outputs are registered from the current (h, v) position, one enabled cycle
// behind the counters.
// Optional macro VTG_TPG_EN adds an 8-bar colour pattern on vid.rgb_out.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  video_timing_if.master        vid
);

  localparam timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int H_TOTAL = total(H_T);
  localparam int V_TOTAL = total(V_T);
  localparam int H_SS    = sync_start(H_T);
  localparam int V_SS    = sync_start(V_T);
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);

  logic [XW-1:0] h;
  logic [YW-1:0] v;
  logic          h_carry;

  vtg_axis_counter #(.W(XW)) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .max   (XW'(H_TOTAL - 1)),
    .count (h),
    .carry (h_carry)
  );

  // v only advances on the h wrap, so vs (decoded from v) changes at h = 0.
  vtg_axis_counter #(.W(YW)) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (h_carry),
    .max   (YW'(V_TOTAL - 1)),
    .count (v),
    .carry ()
  );

  logic de_c, hs_c, vs_c, sof_c, eol_c;

  always_comb begin
    de_c  = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
    hs_c  = (int'(h) >= H_SS) && (int'(h) < H_SS + H_SYNC);
    vs_c  = (int'(v) >= V_SS) && (int'(v) < V_SS + V_SYNC);
    sof_c = (h == '0) && (v == '0);
    eol_c = (int'(h) == H_ACTIVE - 1) && (int'(v) < V_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vid.hs_out    <= ~HS_POL;
      vid.vs_out    <= ~VS_POL;
      vid.de_out    <= 1'b0;
      vid.x_out     <= '0;
      vid.y_out     <= '0;
      vid.sof_out   <= 1'b0;
      vid.eol_out   <= 1'b0;
      vid.frame_cnt <= '0;
    end else if (en) begin
      vid.hs_out  <= hs_c ? HS_POL : ~HS_POL;
      vid.vs_out  <= vs_c ? VS_POL : ~VS_POL;
      vid.de_out  <= de_c;
      vid.x_out   <= de_c ? h : '0;
      vid.y_out   <= de_c ? v : '0;
      vid.sof_out <= sof_c;
      vid.eol_out <= eol_c;
      if (sof_c) begin
        vid.frame_cnt <= vid.frame_cnt + 16'd1;
      end
    end else begin
      vid.sof_out <= 1'b0;
      vid.eol_out <= 1'b0;
    end
  end

`ifdef VTG_TPG_EN
  if (H_ACTIVE % 8 != 0) begin : g_tpg_width_check
    $error("video_timing_gen: H_ACTIVE must be a multiple of 8 for the colour bars");
  end

  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic [2:0] bar_idx;
  assign bar_idx = 3'(int'(h) / BAR_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      vid.rgb_out <= '0;
    end else if (en) begin
      vid.rgb_out <= de_c ? BAR_RGB[bar_idx] : 24'h0;
    end
  end
`endif

endmodule
